// File: rtl/random_prefetch_wb32.sv
`default_nettype none
// ============================================================================
//  Module   : random_prefetch_wb32
//  Purpose  : Wishbone bus-master prefetcher for the multi-stream RNG
//             peripheral. After reset it seeds one stream. It then loops:
//             select the stream, read the current word, step the generator.
//             Fetched words are buffered in a small FIFO and handed to a
//             local consumer over a valid/ready handshake.
//  Ports    : clk_i, rst_ni (async, active-low), reseed_i (pulse)
//             Wishbone master: cyc_o, stb_o, we_o, cti_o, sel_o, adr_o,
//                              dat_o, ack_i, dat_i
//             Consumer side  : rnd_o, rnd_valid_o, rnd_ready_i, level_o
//             Status         : timeout_o (pulse), seeded_o
//  Revision : 1.0 - initial release
// ============================================================================
module random_prefetch_wb32 #(
    parameter logic [31:0] RNG_BASE = 32'hFEE10000,
    parameter logic [9:0]  STREAM   = 10'd0,
    parameter logic [31:0] SEED_Z   = 32'd17,
    parameter logic [31:0] SEED_W   = 32'd3,
    parameter int          DEPTH    = 8,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       reseed_i,
    output logic                       cyc_o,
    output logic                       stb_o,
    output logic                       we_o,
    output logic [2:0]                 cti_o,
    output logic [3:0]                 sel_o,
    output logic [31:0]                adr_o,
    output logic [31:0]                dat_o,
    input  logic                       ack_i,
    input  logic [31:0]                dat_i,
    output logic [31:0]                rnd_o,
    output logic                       rnd_valid_o,
    input  logic                       rnd_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       timeout_o,
    output logic                       seeded_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             LW       = AW + 1;
    localparam logic [LW-1:0]  FULL_LVL = LW'(DEPTH);
    // Last counter value before giving up: TIMEOUT stb cycles in total.
    localparam logic [7:0]     TMO_LAST = TIMEOUT - 8'd1;

    typedef enum logic [2:0] {
        S_SEED_S = 3'd0,
        S_SEED_Z = 3'd1,
        S_SEED_W = 3'd2,
        S_IDLE   = 3'd3,
        S_SEL    = 3'd4,
        S_RD     = 3'd5,
        S_STEP   = 3'd6,
        S_GAP    = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    state_t          ret_q, ret_d;        // state to resume after GAP
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic            seeded_q, seeded_d;
    logic            pend_q, pend_d;      // reseed requested mid-transaction

    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   count_q;
    logic [31:0]     mem_q [DEPTH];

    // Per-state transaction description
    logic            tx_we_w;
    logic [3:0]      tx_off_w;
    logic [31:0]     tx_dat_w;
    state_t          tx_next_w;

    logic            push_w;
    logic            pop_w;
    logic            flush_w;
    logic            kill_w;
    logic            space_w;

    assign kill_w  = pend_q | reseed_i;
    assign space_w = (count_q < FULL_LVL);
    assign pop_w   = (count_q != '0) && rnd_ready_i;

    // ------------------------------------------------------------------
    // Transaction decode: what each bus state writes/reads and where the
    // sequence continues after a successful ack.
    // ------------------------------------------------------------------
    always_comb begin
        tx_we_w   = 1'b1;
        tx_off_w  = 4'h0;
        tx_dat_w  = 32'd0;
        tx_next_w = S_IDLE;
        case (state_q)
            S_SEED_S: begin
                tx_off_w  = 4'h4;
                tx_dat_w  = {22'd0, STREAM};
                tx_next_w = S_SEED_Z;
            end
            S_SEED_Z: begin
                tx_off_w  = 4'h8;
                tx_dat_w  = SEED_Z;
                tx_next_w = S_SEED_W;
            end
            S_SEED_W: begin
                tx_off_w  = 4'hC;
                tx_dat_w  = SEED_W;
                tx_next_w = S_IDLE;
            end
            S_SEL: begin
                tx_off_w  = 4'h4;
                tx_dat_w  = {22'd0, STREAM};
                tx_next_w = S_RD;
            end
            S_RD: begin
                tx_we_w   = 1'b0;
                tx_next_w = S_STEP;
            end
            S_STEP: begin
                tx_next_w = S_IDLE;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and registered bus outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        seeded_d  = seeded_q;
        pend_d    = pend_q;
        flush_w   = 1'b0;
        push_w    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (reseed_i) begin
                    flush_w = 1'b1;
                    state_d = S_SEED_S;
                end else if (space_w) begin
                    state_d = S_SEL;
                end
            end

            S_GAP: begin
                if (kill_w) begin
                    flush_w = 1'b1;
                    state_d = S_SEED_S;
                end else if (ret_q == S_IDLE && space_w) begin
                    // Skip the IDLE cycle when a fetch can start at once.
                    state_d = S_SEL;
                end else begin
                    state_d = ret_q;
                end
            end

            default: begin
                // A request arriving mid-transaction waits for it to end.
                pend_d = kill_w;
                if (!cyc_q) begin
                    cyc_d = 1'b1;
                    we_d  = tx_we_w;
                    adr_d = RNG_BASE + {28'd0, tx_off_w};
                    dat_d = tx_dat_w;
                    cnt_d = 8'd0;
                end else if (ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    adr_d   = 32'd0;
                    dat_d   = 32'd0;
                    state_d = S_GAP;
                    ret_d   = tx_next_w;
                    if (state_q == S_RD && !kill_w) begin
                        push_w = 1'b1;
                    end
                    if (state_q == S_SEED_W && !kill_w) begin
                        seeded_d = 1'b1;
                    end
                end else if (cnt_q == TMO_LAST) begin
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    adr_d     = 32'd0;
                    dat_d     = 32'd0;
                    timeout_d = 1'b1;
                    state_d   = S_GAP;
                    ret_d     = state_q;   // retry the same transaction
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
        endcase

        if (flush_w) begin
            seeded_d = 1'b0;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_SEED_S;
            ret_q     <= S_IDLE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= 32'd0;
            dat_q     <= 32'd0;
            cnt_q     <= 8'd0;
            timeout_q <= 1'b0;
            seeded_q  <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            seeded_q  <= seeded_d;
            pend_q    <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO. A fetch only starts with space available and only one fetch
    // is ever outstanding, so a push never meets a full FIFO.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_w) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_w) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_w && !pop_w) begin
                count_q <= count_q + 1'b1;
            end else if (!push_w && pop_w) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cyc_o       = cyc_q;
    assign stb_o       = cyc_q;
    assign we_o        = we_q;
    assign cti_o       = 3'b111;
    assign sel_o       = 4'hF;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    // Gated so the RAM's unreset contents never reach the consumer.
    assign rnd_o       = (count_q != '0) ? mem_q[rd_ptr_q] : 32'd0;
    assign rnd_valid_o = (count_q != '0);
    assign level_o     = count_q;
    assign timeout_o   = timeout_q;
    assign seeded_o    = seeded_q;

endmodule
`default_nettype wire

// File: tb/tb_random_prefetch_wb32.sv
`default_nettype none
// ============================================================================
//  Module   : tb_random_prefetch_wb32
//  Purpose  : Bench for random_prefetch_wb32 with an RNG peripheral model on
//             the bus and a scoreboard of expected words on the consumer side.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_random_prefetch_wb32;

    localparam logic [31:0] BASE  = 32'hFEE10000;
    localparam logic [31:0] SZ    = 32'd17;
    localparam logic [31:0] SW    = 32'd3;
    localparam logic [31:0] FIRST = 32'h00110003;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } xact_t;

    logic        clk;
    logic        rst_n;
    logic        reseed;
    logic        cyc_o, stb_o, we_o;
    logic [2:0]  cti_o;
    logic [3:0]  sel_o;
    logic [31:0] adr_o, dat_o;
    logic        ack_i;
    logic [31:0] dat_i;
    logic [31:0] rnd_o;
    logic        rnd_valid_o;
    logic        ready;
    logic [3:0]  level_o;
    logic        timeout_o;
    logic        seeded_o;

    int          n_cmp = 0;
    int          n_bad = 0;

    // Bench state
    xact_t       log_q[$];
    logic [31:0] exp_q[$];
    int          slv_lat   = 1;
    bit          noack_rd  = 0;
    bit          reseeding = 1;
    logic [31:0] sz_r, sw_r, gz, gw;
    int          run_len = 0;
    int          last_run = 0;

    random_prefetch_wb32 dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .reseed_i    (reseed),
        .cyc_o       (cyc_o),
        .stb_o       (stb_o),
        .we_o        (we_o),
        .cti_o       (cti_o),
        .sel_o       (sel_o),
        .adr_o       (adr_o),
        .dat_o       (dat_o),
        .ack_i       (ack_i),
        .dat_i       (dat_i),
        .rnd_o       (rnd_o),
        .rnd_valid_o (rnd_valid_o),
        .rnd_ready_i (ready),
        .level_o     (level_o),
        .timeout_o   (timeout_o),
        .seeded_o    (seeded_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Generator arithmetic, straight from the peripheral's definition.
    function automatic logic [31:0] rng_out(input logic [31:0] z, input logic [31:0] w);
        return {z[15:0], 16'h0} + w;
    endfunction
    function automatic logic [31:0] z_next(input logic [31:0] z);
        return 32'd36969 * {16'h0, z[15:0]} + {16'h0, z[31:16]};
    endfunction
    function automatic logic [31:0] w_next(input logic [31:0] w);
        return 32'd18000 * {16'h0, w[15:0]} + {16'h0, w[31:16]};
    endfunction

    // RNG peripheral slave: acks after slv_lat strobe cycles. Each RD ack
    // also pushes the next word of the reference sequence (restarted at the
    // seeds once the seed sequence completes) into the expected queue.
    initial begin : slave
        int seen;
        seen  = 0;
        ack_i = 1'b0;
        dat_i = 32'd0;
        sz_r  = 32'd0;
        sw_r  = 32'd0;
        gz    = SZ;
        gw    = SW;
        forever begin
            @(negedge clk);
            ack_i = 1'b0;
            dat_i = 32'd0;
            if (!rst_n || !cyc_o) begin
                seen = 0;
            end else begin
                seen++;
                if (!(noack_rd && !we_o) && seen >= slv_lat) begin
                    ack_i = 1'b1;
                    seen  = 0;
                    log_q.push_back({we_o, adr_o, dat_o});
                    if (we_o) begin
                        if (adr_o == BASE + 32'h8) sz_r = dat_o;
                        if (adr_o == BASE + 32'hC) begin
                            sw_r = dat_o;
                            if (reseeding) begin
                                reseeding = 0;
                                gz = SZ;
                                gw = SW;
                            end
                        end
                        if (adr_o == BASE) begin
                            sz_r = z_next(sz_r);
                            sw_r = w_next(sw_r);
                        end
                    end else begin
                        dat_i = rng_out(sz_r, sw_r);
                        if (!reseeding) begin
                            exp_q.push_back(rng_out(gz, gw));
                            gz = z_next(gz);
                            gw = w_next(gw);
                        end
                    end
                end
            end
        end
    end

    // Consumer-side monitor
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n && rnd_valid_o && ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_without_expectation", {64'd0, rnd_o}, 96'hDEAD);
                end else begin
                    chk("rnd_word", {64'd0, rnd_o}, {64'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Strobe run-length tracker
    initial begin : runlen
        forever begin
            @(negedge clk);
            if (cyc_o) begin
                run_len++;
            end else if (run_len != 0) begin
                last_run = run_len;
                run_len  = 0;
            end
        end
    end

    initial begin : main
        int     k;
        int     n;
        logic [3:0] lvl0;
        logic   prev_cyc;
        rst_n  = 1'b0;
        reseed = 1'b0;
        ready  = 1'b0;

        // ---------------- reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cyc_stb_we", {cyc_o, stb_o, we_o}, 3'b000);
        chk("rst_adr", adr_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_cti_sel", {cti_o, sel_o}, 7'b111_1111);
        chk("rst_rnd", {rnd_valid_o, rnd_o}, 0);
        chk("rst_level", level_o, 0);
        chk("rst_tmo_seeded", {timeout_o, seeded_o}, 2'b00);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_clk_stb", {cyc_o, stb_o}, 2'b11);
        chk("first_clk_xact", {we_o, adr_o, dat_o}, {1'b1, BASE + 32'h4, 32'd0});

        // ---------------- seed sequence, zero-wait slave
        k = 0;
        while (!seeded_o && k < 200) begin @(negedge clk); k++; end
        chk("seeded_rise", seeded_o, 1);
        chk("seed_xact_count", log_q.size(), 3);
        if (log_q.size() >= 3) begin
            chk("seed_write_s", log_q[0], {1'b1, BASE + 32'h4, 32'h0});
            chk("seed_write_z", log_q[1], {1'b1, BASE + 32'h8, 32'h11});
            chk("seed_write_w", log_q[2], {1'b1, BASE + 32'hC, 32'h3});
        end

        // ---------------- fill with consumer stalled
        k = 0;
        while (level_o != 4'd8 && k < 500) begin @(negedge clk); k++; end
        chk("fill_level", level_o, 8);
        repeat (40) @(negedge clk);
        chk("full_xact_count", log_q.size(), 27);
        chk("full_level_hold", level_o, 8);
        chk("head_word", rnd_o, FIRST);

        // ---------------- pop one word, expect exactly one refetch
        @(posedge clk); #1; ready = 1'b1;
        @(posedge clk); #1; ready = 1'b0;
        repeat (40) @(negedge clk);
        chk("refetch_xact_count", log_q.size(), 30);
        chk("refetch_level", level_o, 8);
        n = log_q.size();
        if (n >= 3) begin
            chk("refetch_sel", log_q[n-3], {1'b1, BASE + 32'h4, 32'h0});
            chk("refetch_rd", {log_q[n-2].we, log_q[n-2].adr}, {1'b0, BASE});
            chk("refetch_step", log_q[n-1], {1'b1, BASE, 32'h0});
        end

        // ---------------- random consumer, peripheral latency
        slv_lat = 2;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            ready = ($urandom % 2) == 1;
        end

        // ---------------- RD timeout and retry
        @(posedge clk); #1;
        ready    = 1'b1;
        noack_rd = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        ready = 1'b0;
        @(negedge clk);
        lvl0 = level_o;
        k = 0;
        while (!timeout_o && k < 600) begin @(negedge clk); k++; end
        chk("timeout_pulse", timeout_o, 1);
        chk("timeout_level", level_o, lvl0);
        @(posedge clk); #1;
        chk("timeout_stb_cycles", last_run, 255);
        @(negedge clk);
        chk("timeout_one_cycle", timeout_o, 0);
        k = 0;
        while (!(cyc_o && !we_o && adr_o == BASE) && k < 10) begin @(negedge clk); k++; end
        chk("rd_retry", {cyc_o, we_o, adr_o}, {1'b1, 1'b0, BASE});
        @(posedge clk); #1;
        noack_rd = 1'b0;
        k = 0;
        while (level_o == lvl0 && k < 20) begin @(negedge clk); k++; end
        chk("retry_push", level_o, lvl0 + 4'd1);

        // ---------------- reseed during RD with 5 words buffered
        @(posedge clk); #1;
        ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        ready = 1'b0;
        prev_cyc = cyc_o;
        k = 0;
        while (k < 1000) begin
            @(posedge clk); #1;
            if (cyc_o && !prev_cyc && !we_o && level_o == 4'd5) break;
            prev_cyc = cyc_o;
            k++;
        end
        chk("reseed_rd_found", {cyc_o, we_o, level_o}, {1'b1, 1'b0, 4'd5});
        reseed    = 1'b1;
        reseeding = 1;
        exp_q.delete();
        @(posedge clk); #1;
        reseed = 1'b0;
        k = 0;
        while (seeded_o && k < 50) begin @(negedge clk); k++; end
        chk("reseed_seeded_clr", seeded_o, 0);
        chk("reseed_flush", {rnd_valid_o, level_o}, 5'd0);
        k = 0;
        while (!seeded_o && k < 200) begin @(negedge clk); k++; end
        chk("reseed_seeded_set", seeded_o, 1);
        n = log_q.size();
        if (n >= 3) begin
            chk("reseed_write_s", log_q[n-3], {1'b1, BASE + 32'h4, 32'h0});
            chk("reseed_write_z", log_q[n-2], {1'b1, BASE + 32'h8, 32'h11});
            chk("reseed_write_w", log_q[n-1], {1'b1, BASE + 32'hC, 32'h3});
        end
        k = 0;
        while (!rnd_valid_o && k < 100) begin @(negedge clk); k++; end
        chk("reseed_first_word", rnd_o, FIRST);
        chk("reseed_first_level", level_o, 1);

        // ---------------- async reset during STEP
        k = 0;
        while (!(cyc_o && we_o && adr_o == BASE) && k < 200) begin @(negedge clk); k++; end
        chk("step_found", {cyc_o, we_o, adr_o}, {1'b1, 1'b1, BASE});
        #2;
        rst_n     = 1'b0;
        reseeding = 1;
        exp_q.delete();
        #1;
        chk("async_rst_bus", {cyc_o, stb_o, we_o, adr_o, dat_o}, 0);
        chk("async_rst_fifo", {rnd_valid_o, rnd_o, level_o}, 0);
        chk("async_rst_status", {timeout_o, seeded_o}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("restart_seed_s", {cyc_o, we_o, adr_o}, {1'b1, 1'b1, BASE + 32'h4});
        k = 0;
        while (!rnd_valid_o && k < 300) begin @(negedge clk); k++; end
        chk("restart_first_word", rnd_o, FIRST);
        @(posedge clk); #1;
        ready = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
